// File: rtl/instr_assembler_if.sv
// rtl/instr_assembler_if.sv - request and instruction-stream signals of instr_assembler
interface instr_assembler_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ExtOp;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, ExtOp, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, ExtOp, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - packs RV32I fields and immediate into words, queues them with write addresses
module instr_assembler #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  instr_assembler_if.slave bus,
  output logic             err_sticky,
  output logic [7:0]       err_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_sticky_q, err_sticky_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [31:0] word;
  logic        legal;
  logic        fits_12, fits_13, fits_21;
  logic        accept, push, pop;

  // Immediate must be a sign-extension of the bits the format can carry.
  assign fits_12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign fits_13 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign fits_21 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (bus.ExtOp)
      3'b000: begin
        word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        legal = fits_12;
      end
      3'b001: begin
        word  = {bus.imm[31:12], bus.rd, bus.opcode};
        legal = (bus.imm[11:0] == 12'h000);
      end
      3'b010: begin
        word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        legal = fits_12;
      end
      3'b011: begin
        word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                 bus.imm[4:1], bus.imm[11], bus.opcode};
        legal = fits_13 & ~bus.imm[0];
      end
      3'b100: begin
        word  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
        legal = fits_21 & ~bus.imm[0];
      end
      3'b101: begin
        word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // in_ready depends only on stored occupancy, so a pop never frees a slot in the same cycle.
  assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = mem_q[rd_ptr_q];
  assign bus.out_addr  = addr_q;
  assign err_sticky    = err_sticky_q;
  assign err_cnt       = err_cnt_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & legal;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (clear) begin
      addr_d       = BASE_ADDR;
      err_sticky_d = 1'b0;
      err_cnt_d    = 8'd0;
    end else begin
      if (pop) begin
        addr_d = addr_q + ADDR_W'(4);
      end
      if (accept && !legal) begin
        err_sticky_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= BASE_ADDR;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end
endmodule
